mod12_count_checker: RTL



---
 rtl/mod12_count_checker_if.sv | 29 ++
 rtl/mod12_count_checker.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mod12_count_checker_if.sv
// Signal bundle between a mod-12 up/down counter (plus its stimulus) and the observer
// that checks it. The master drives the counter-side signals; the checker is the slave.
interface mod12_count_checker_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 chk_en;
   logic                 dut_rst;
   logic                 load;
   logic                 mode;
   logic [WIDTH-1:0]     data_in;
   logic [WIDTH-1:0]     data_out;
   logic [WIDTH-1:0]     exp_out;
   logic                 mismatch;
   logic                 range_err;
   logic                 wrap_up;
   logic                 wrap_dn;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output chk_en, dut_rst, load, mode, data_in, data_out,
      input  exp_out, mismatch, range_err, wrap_up, wrap_dn, err_count
   );

   modport slave (
      input  chk_en, dut_rst, load, mode, data_in, data_out,
      output exp_out, mismatch, range_err, wrap_up, wrap_dn, err_count
   );
endinterface

// File: rtl/mod12_count_checker.sv
// Observer for a mod-12 up/down counter: predicts each output from the previously observed
// sample, flags mismatches, out-of-range values and wraps, and keeps a saturating error count.
module mod12_count_checker #(
   parameter int MOD       = 12,
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
) (
   input logic                  clk,
   input logic                  rst,
   mod12_count_checker_if.slave bus
);

   typedef enum logic [1:0] {COLD, PRIME, ARMED} state_t;

   localparam logic [WIDTH-1:0]     MaxVal = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0]     One    = WIDTH'(1);
   localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

   state_t               state_q, state_d;
   logic                 pDutRst_q, pDutRst_d;
   logic                 pLoad_q, pLoad_d;
   logic                 pMode_q, pMode_d;
   logic [WIDTH-1:0]     pDataIn_q, pDataIn_d;
   logic [WIDTH-1:0]     pDataOut_q, pDataOut_d;
   logic [WIDTH-1:0]     expOut_q, expOut_d;
   logic                 mismatch_q, mismatch_d;
   logic                 rangeErr_q, rangeErr_d;
   logic                 wrapUp_q, wrapUp_d;
   logic                 wrapDn_q, wrapDn_d;
   logic [ERR_CNT_W-1:0] errCount_q, errCount_d;
   logic [WIDTH-1:0]     pred;
   logic [ERR_CNT_W:0]   errSum;

   // Out-of-range previous values predict 0 ahead of counting; reset and load still win.
   function automatic logic [WIDTH-1:0] predict(input logic rstS, input logic loadS,
                                                input logic modeS, input logic [WIDTH-1:0] din,
                                                input logic [WIDTH-1:0] dout);
      if (rstS)              return '0;
      else if (loadS)        return din;
      else if (dout > MaxVal) return '0;
      else if (modeS)        return (dout == MaxVal) ? '0 : dout + One;
      else                   return (dout == '0) ? MaxVal : dout - One;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= COLD;
         pDutRst_q  <= 1'b0;
         pLoad_q    <= 1'b0;
         pMode_q    <= 1'b0;
         pDataIn_q  <= '0;
         pDataOut_q <= '0;
         expOut_q   <= '0;
         mismatch_q <= 1'b0;
         rangeErr_q <= 1'b0;
         wrapUp_q   <= 1'b0;
         wrapDn_q   <= 1'b0;
         errCount_q <= '0;
      end else begin
         state_q    <= state_d;
         pDutRst_q  <= pDutRst_d;
         pLoad_q    <= pLoad_d;
         pMode_q    <= pMode_d;
         pDataIn_q  <= pDataIn_d;
         pDataOut_q <= pDataOut_d;
         expOut_q   <= expOut_d;
         mismatch_q <= mismatch_d;
         rangeErr_q <= rangeErr_d;
         wrapUp_q   <= wrapUp_d;
         wrapDn_q   <= wrapDn_d;
         errCount_q <= errCount_d;
      end
   end

   // Prediction always comes from the observed sample, so one glitch costs one mismatch.
   assign pred = predict(pDutRst_q, pLoad_q, pMode_q, pDataIn_q, pDataOut_q);

   always_comb begin
      state_d    = state_q;
      pDutRst_d  = pDutRst_q;
      pLoad_d    = pLoad_q;
      pMode_d    = pMode_q;
      pDataIn_d  = pDataIn_q;
      pDataOut_d = pDataOut_q;
      expOut_d   = expOut_q;
      mismatch_d = 1'b0;
      rangeErr_d = 1'b0;
      wrapUp_d   = 1'b0;
      wrapDn_d   = 1'b0;
      if (bus.chk_en) begin
         state_d    = (state_q == COLD) ? PRIME : ARMED;
         pDutRst_d  = bus.dut_rst;
         pLoad_d    = bus.load;
         pMode_d    = bus.mode;
         pDataIn_d  = bus.data_in;
         pDataOut_d = bus.data_out;
         expOut_d   = predict(bus.dut_rst, bus.load, bus.mode, bus.data_in, bus.data_out);
         if (state_q == ARMED) begin
            mismatch_d = (bus.data_out != pred);
            rangeErr_d = (bus.data_out > MaxVal) || (pLoad_q && (pDataIn_q > MaxVal));
            wrapUp_d   = pMode_q && !pLoad_q && !pDutRst_q && (pDataOut_q == MaxVal) &&
                         (bus.data_out == '0) && (bus.data_out == pred);
            wrapDn_d   = !pMode_q && !pLoad_q && !pDutRst_q && (pDataOut_q == '0) &&
                         (bus.data_out == MaxVal) && (bus.data_out == pred);
         end
      end else begin
         state_d = PRIME;
      end
      errSum     = {1'b0, errCount_q} + (ERR_CNT_W+1)'(mismatch_d) + (ERR_CNT_W+1)'(rangeErr_d);
      errCount_d = (errSum > {1'b0, ErrMax}) ? ErrMax : errSum[ERR_CNT_W-1:0];
   end

   assign bus.exp_out   = expOut_q;
   assign bus.mismatch  = mismatch_q;
   assign bus.range_err = rangeErr_q;
   assign bus.wrap_up   = wrapUp_q;
   assign bus.wrap_dn   = wrapDn_q;
   assign bus.err_count = errCount_q;

endmodule
